// File: rtl/bcd_converter_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : bcd_converter_seq_if
// Brief   : Start/done handshake and result bus of the sequential BCD converter.
// Rev     : 1.0
// ============================================================================
interface bcd_converter_seq_if #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, blank
    );
endinterface
`default_nettype wire

// File: rtl/bcd_converter_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd_converter_seq
// Brief   : Double-dabble binary-to-BCD converter, one input bit per clock.
//           Define BCD_BLANK_EN to enable the leading-zero blank mask.
// Rev     : 1.0
// ============================================================================
module bcd_converter_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_converter_seq_if.slave  bus
);
    localparam int c_work_w = 4 * DIGITS;
    localparam int c_cnt_w  = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BIN_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [BIN_W-1:0]      r_in;
    logic [c_work_w-1:0]   r_work;
    logic                  r_ovf_acc;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_work_w-1:0]   r_bcd;
    logic                  r_overflow;

    logic [c_work_w-1:0]   w_adj;
    logic [c_work_w-1:0]   w_work_next;
    logic                  w_ovf_next;
    logic                  w_last;
    logic                  w_accept;

    // Add-3 correction is per nibble; no carry propagates between digits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] > 4'd4) ?
                                      (r_work[4*gi +: 4] + 4'd3) :
                                      r_work[4*gi +: 4];
        end
    endgenerate

    // Bits leaving the top nibble are the lost higher decades: any 1 means overflow.
    assign w_work_next = {w_adj[c_work_w-2:0], r_in[BIN_W-1]};
    assign w_ovf_next  = r_ovf_acc | w_adj[c_work_w-1];
    assign w_last      = (r_cnt == c_last_cnt);
    assign w_accept    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_DONE;
            S_DONE:  w_next_state = bus.start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in       <= '0;
            r_work     <= '0;
            r_ovf_acc  <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_in      <= bus.bin;
                r_work    <= '0;
                r_ovf_acc <= 1'b0;
                r_cnt     <= '0;
            end else if (r_state == S_SHIFT) begin
                r_in      <= r_in << 1;
                r_work    <= w_work_next;
                r_ovf_acc <= w_ovf_next;
                r_cnt     <= r_cnt + c_cnt_one;
                if (w_last) begin
                    r_bcd      <= w_work_next;
                    r_overflow <= w_ovf_next;
                end
            end
        end
    end

    assign bus.busy     = (r_state == S_SHIFT);
    assign bus.done     = (r_state == S_DONE);
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;
    logic              w_zero_run;

    // Scan from the top digit down; a digit blanks only while everything above is zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (w_work_next[4*i +: 4] == 4'd0);
            w_blank[i] = w_zero_run;
        end
        if (w_ovf_next) begin
            w_blank = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= '0;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_blank <= w_blank;
        end
    end

    assign bus.blank = r_blank;
`else
    assign bus.blank = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_converter_seq
// Brief   : Randomized self-checking bench; DIGITS=4 and DIGITS=3 instances in lockstep.
// Rev     : 1.0
// ============================================================================
module tb_bcd_converter_seq;
    localparam int BIN_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    int               n_total = 0;
    int               n_bad = 0;

    bcd_converter_seq_if #(.BIN_W(BIN_W), .DIGITS(4)) bus4 ();
    bcd_converter_seq_if #(.BIN_W(BIN_W), .DIGITS(3)) bus3 ();

    assign bus4.start = start;
    assign bus4.bin   = bin;
    assign bus3.start = start;
    assign bus3.bin   = bin;

    bcd_converter_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    bcd_converter_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of (v mod 10^d), one per nibble.
    function automatic logic [31:0] model_bcd(input int v, input int d);
        logic [31:0] r = '0;
        int m = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_ovf(input int v, input int d);
        return {31'd0, (v >= pow10(d))};
    endfunction

    // Digit i (i>=1) blanks when the value is below 10^i; nothing blanks on overflow.
    function automatic logic [31:0] model_blank(input int v, input int d);
        logic [31:0] r = '0;
`ifdef BCD_BLANK_EN
        if (v < pow10(d)) begin
            for (int i = 1; i < d; i++) begin
                if (v < pow10(i)) r[i] = 1'b1;
            end
        end
`endif
        return r;
    endfunction

    task automatic check_outputs(input int v, input string tag);
        check({tag, ".done4"}, {31'd0, bus4.done}, 32'd1);
        check({tag, ".busy4"}, {31'd0, bus4.busy}, 32'd0);
        check({tag, ".done3"}, {31'd0, bus3.done}, 32'd1);
        check({tag, ".bcd4"},  {16'd0, bus4.bcd}, model_bcd(v, 4));
        check({tag, ".ovf4"},  {31'd0, bus4.overflow}, model_ovf(v, 4));
        check({tag, ".blank4"}, {28'd0, bus4.blank}, model_blank(v, 4));
        check({tag, ".bcd3"},  {20'd0, bus3.bcd}, model_bcd(v, 3));
        check({tag, ".ovf3"},  {31'd0, bus3.overflow}, model_ovf(v, 3));
        check({tag, ".blank3"}, {29'd0, bus3.blank}, model_blank(v, 3));
    endtask

    task automatic launch(input int v);
        start = 1'b1;
        bin   = BIN_W'(v);
    endtask

    // Called with start already raised; start/bin are scrambled during SHIFT.
    task automatic wait_done(input int v, input string tag, input bit chain, input int next_v);
        int lat = 0;
        int nb  = 0;
        @(posedge clk); #1;
        while (!bus4.done && lat < 60) begin
            if (bus4.busy) nb++;
            start = 1'($urandom_range(0, 1));
            bin   = BIN_W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, BIN_W);
        check({tag, ".busy_cycles"}, nb, BIN_W);
        check_outputs(v, tag);
        if (chain) begin
            launch(next_v);
        end else begin
            start = 1'b0;
            @(posedge clk); #1;
            check({tag, ".done_once"}, {31'd0, bus4.done}, 32'd0);
            check({tag, ".idle_busy"}, {31'd0, bus4.busy}, 32'd0);
            check({tag, ".held_bcd"}, {16'd0, bus4.bcd}, model_bcd(v, 4));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".busy"}, {31'd0, bus4.busy}, 32'd0);
        check({tag, ".done"}, {31'd0, bus4.done}, 32'd0);
        check({tag, ".bcd4"}, {16'd0, bus4.bcd}, 32'd0);
        check({tag, ".ovf4"}, {31'd0, bus4.overflow}, 32'd0);
        check({tag, ".blank4"}, {28'd0, bus4.blank}, 32'd0);
        check({tag, ".bcd3"}, {20'd0, bus3.bcd}, 32'd0);
    endtask

    initial begin
        int cur;
        int nxt;
        int quiet;
        bit ch;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        launch(4095); wait_done(4095, "max", 1'b0, 0);

        launch(0);
        wait_done(0,  "b2b0",  1'b1, 9);
        wait_done(9,  "b2b9",  1'b1, 10);
        wait_done(10, "b2b10", 1'b0, 0);

        launch(999);  wait_done(999,  "d3_999",  1'b0, 0);
        launch(1000); wait_done(1000, "d3_1000", 1'b0, 0);
        launch(123);  wait_done(123,  "ignore_start", 1'b0, 0);

        // Abort mid-conversion: outputs clear and no done follows.
        launch(777);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check_cleared("abort");
        rst = 1'b0;
        quiet = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus4.done || bus4.busy) quiet++;
        end
        check("abort.no_done", quiet, 0);
        launch(42); wait_done(42, "after_abort", 1'b0, 0);

        launch(7);   wait_done(7,   "blank7",   1'b0, 0);
        launch(305); wait_done(305, "blank305", 1'b0, 0);
        launch(0);   wait_done(0,   "blank0",   1'b0, 0);

        cur = int'($urandom_range(0, 4095));
        launch(cur);
        for (int i = 0; i < 24; i++) begin
            nxt = int'($urandom_range(0, 4095));
            ch  = 1'($urandom_range(0, 1));
            wait_done(cur, "rnd", ch, nxt);
            if (!ch) launch(nxt);
            cur = nxt;
        end
        wait_done(cur, "rnd_last", 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
